// File: rtl/usb_out_ep_buffer.sv
// Receive buffer for one USB full-speed OUT endpoint: packets are written
// speculatively, then committed or rewound on CRC and data-toggle result.
module usb_out_ep_buffer #(
    parameter int DEPTH   = 128,
    parameter int MAX_PKT = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_pkt_start,
    input  logic       rx_pkt_setup,
    input  logic       rx_pid_data1,
    input  logic       rx_data_put,
    input  logic [7:0] rx_data,
    input  logic       rx_pkt_end,
    input  logic       rx_pkt_valid,
    output logic       ep_ready,
    output logic       ep_stall,
    input  logic       out_ep_req,
    output logic       out_ep_grant,
    output logic       out_ep_data_avail,
    output logic       out_ep_setup,
    input  logic       out_ep_data_get,
    output logic [7:0] out_ep_data,
    input  logic       out_ep_stall,
    output logic       out_ep_acked
);
    // state   | meaning
    // RX_IDLE | no packet in progress
    // RX_DATA | storing payload bytes speculatively past commit_ptr
    // RX_DROP | packet overflowed; ignore bytes, rewind at end

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);
    localparam logic [PW-1:0] MAX_V   = PW'(MAX_PKT);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_DROP} rx_state_t;

    rx_state_t     state_q, state_d;
    logic [PW-1:0] rd_ptr, commit_ptr, wr_ptr;
    logic [PW-1:0] rd_d, commit_d, wr_d;
    logic          toggle_q, toggle_d;
    logic          pid_q, pid_d;
    logic          setup_pkt_q, setup_pkt_d;
    logic          acked_d, setup_commit, wr_en, pid_ok;
    logic          empty, full, get_ok;
    logic [PW-1:0] used, pkt_cnt, free_cnt;
    logic [7:0]    mem [DEPTH];

    assign empty             = (rd_ptr == commit_ptr);
    assign used              = wr_ptr - rd_ptr;
    assign full              = (used == DEPTH_V);
    assign free_cnt          = DEPTH_V - used;
    assign pkt_cnt           = wr_ptr - commit_ptr;
    assign out_ep_data_avail = !empty;
    assign get_ok            = out_ep_data_get && out_ep_grant && !empty;
    // SETUP must arrive as DATA0 regardless of the current toggle
    assign pid_ok            = setup_pkt_q ? !pid_q : (pid_q == toggle_q);
    assign rd_d              = get_ok ? rd_ptr + PW'(1) : rd_ptr;

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_ptr;
        commit_d     = commit_ptr;
        toggle_d     = toggle_q;
        pid_d        = pid_q;
        setup_pkt_d  = setup_pkt_q;
        acked_d      = 1'b0;
        setup_commit = 1'b0;
        wr_en        = 1'b0;
        if (rx_pkt_start) begin
            wr_d        = commit_ptr;
            pid_d       = rx_pid_data1;
            setup_pkt_d = rx_pkt_setup;
            state_d     = RX_DATA;
        end else begin
            case (state_q)
                RX_DATA: begin
                    if (rx_pkt_end) begin
                        state_d = RX_IDLE;
                        wr_d    = commit_ptr;
                        if (rx_pkt_valid) begin
                            acked_d = 1'b1;
                            if (pid_ok) begin
                                commit_d = wr_ptr;
                                wr_d     = wr_ptr;
                                if (setup_pkt_q) begin
                                    toggle_d     = 1'b1;
                                    setup_commit = 1'b1;
                                end else begin
                                    toggle_d = !toggle_q;
                                end
                            end
                        end
                    end else if (rx_data_put) begin
                        if (full || pkt_cnt == MAX_V) begin
                            state_d = RX_DROP;
                        end else begin
                            wr_en = 1'b1;
                            wr_d  = wr_ptr + PW'(1);
                        end
                    end
                end
                RX_DROP: begin
                    if (rx_pkt_end) begin
                        state_d = RX_IDLE;
                        wr_d    = commit_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RX_IDLE;
            rd_ptr       <= '0;
            commit_ptr   <= '0;
            wr_ptr       <= '0;
            toggle_q     <= 1'b0;
            pid_q        <= 1'b0;
            setup_pkt_q  <= 1'b0;
            out_ep_acked <= 1'b0;
            out_ep_setup <= 1'b0;
            out_ep_grant <= 1'b0;
            out_ep_data  <= 8'h00;
            ep_ready     <= 1'b1;
            ep_stall     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr       <= rd_d;
            commit_ptr   <= commit_d;
            wr_ptr       <= wr_d;
            toggle_q     <= toggle_d;
            pid_q        <= pid_d;
            setup_pkt_q  <= setup_pkt_d;
            out_ep_acked <= acked_d;
            out_ep_grant <= out_ep_req;
            ep_ready     <= (free_cnt >= MAX_V);
            ep_stall     <= out_ep_stall;
            if (get_ok) out_ep_data <= mem[rd_ptr[AW-1:0]];
            // a fresh SETUP commit wins over draining the previous one
            if (setup_commit) out_ep_setup <= 1'b1;
            else if (get_ok && rd_d == commit_ptr) out_ep_setup <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= rx_data;
    end
endmodule

// File: tb/tb_usb_out_ep_buffer.sv
// Directed bench for usb_out_ep_buffer: packet commit/rewind, toggle,
// overflow drop, SETUP flag, grant and simultaneous put/get across the wrap.
module tb_usb_out_ep_buffer;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_pkt_start, rx_pkt_setup, rx_pid_data1, rx_data_put;
    logic [7:0] rx_data;
    logic       rx_pkt_end, rx_pkt_valid;
    logic       ep_ready, ep_stall;
    logic       out_ep_req, out_ep_grant, out_ep_data_avail, out_ep_setup;
    logic       out_ep_data_get;
    logic [7:0] out_ep_data;
    logic       out_ep_stall, out_ep_acked;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] pkt_buf [64];
    logic [7:0] exp_q [$];
    logic       ack;
    logic [7:0] last_data;

    usb_out_ep_buffer #(.DEPTH(128), .MAX_PKT(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_pkt_start(rx_pkt_start), .rx_pkt_setup(rx_pkt_setup),
        .rx_pid_data1(rx_pid_data1), .rx_data_put(rx_data_put),
        .rx_data(rx_data), .rx_pkt_end(rx_pkt_end), .rx_pkt_valid(rx_pkt_valid),
        .ep_ready(ep_ready), .ep_stall(ep_stall),
        .out_ep_req(out_ep_req), .out_ep_grant(out_ep_grant),
        .out_ep_data_avail(out_ep_data_avail), .out_ep_setup(out_ep_setup),
        .out_ep_data_get(out_ep_data_get), .out_ep_data(out_ep_data),
        .out_ep_stall(out_ep_stall), .out_ep_acked(out_ep_acked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drives one packet from pkt_buf; ack is sampled the cycle after rx_pkt_end
    task automatic send_pkt(input logic setup, input logic pid, input int n,
                            input logic valid, output logic ack_o);
        rx_pkt_start = 1'b1; rx_pkt_setup = setup; rx_pid_data1 = pid;
        tick();
        rx_pkt_start = 1'b0; rx_pkt_setup = 1'b0; rx_pid_data1 = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx_data_put = 1'b1; rx_data = pkt_buf[i];
            tick();
        end
        rx_data_put = 1'b0;
        rx_pkt_end = 1'b1; rx_pkt_valid = valid;
        tick();
        ack_o = out_ep_acked;
        rx_pkt_end = 1'b0; rx_pkt_valid = 1'b0;
        tick();
        chk("acked_one_cycle", out_ep_acked, 0);
    endtask

    task automatic read_n(input int n, input string tag);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            out_ep_data_get = 1'b1;
            tick();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            chk(tag, out_ep_data, e);
        end
        out_ep_data_get = 1'b0;
    endtask

    task automatic push_pkt(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(pkt_buf[i]);
    endtask

    initial begin
        reset_n = 1'b0;
        rx_pkt_start = 0; rx_pkt_setup = 0; rx_pid_data1 = 0; rx_data_put = 0;
        rx_data = 0; rx_pkt_end = 0; rx_pkt_valid = 0;
        out_ep_req = 0; out_ep_data_get = 0; out_ep_stall = 0;
        tick(); tick();
        chk("rst_grant", out_ep_grant, 0);
        chk("rst_avail", out_ep_data_avail, 0);
        chk("rst_setup", out_ep_setup, 0);
        chk("rst_acked", out_ep_acked, 0);
        chk("rst_stall", ep_stall, 0);
        chk("rst_data", out_ep_data, 8'h00);
        chk("rst_ready", ep_ready, 1);
        reset_n = 1'b1;
        out_ep_req = 1'b1;
        tick();
        chk("grant_rise", out_ep_grant, 1);

        // DATA0, 4 bytes
        pkt_buf[0] = 8'h11; pkt_buf[1] = 8'h22; pkt_buf[2] = 8'h33; pkt_buf[3] = 8'h44;
        send_pkt(0, 0, 4, 1, ack);
        chk("p1_ack", ack, 1);
        chk("p1_avail", out_ep_data_avail, 1);
        chk("p1_setup", out_ep_setup, 0);
        push_pkt(4);
        read_n(4, "p1_data");
        chk("p1_avail_after", out_ep_data_avail, 0);
        out_ep_data_get = 1'b1;
        tick();
        out_ep_data_get = 1'b0;
        chk("get_empty_holds", out_ep_data, 8'h44);

        // duplicate DATA0: acked but discarded
        send_pkt(0, 0, 4, 1, ack);
        chk("dup_ack", ack, 1);
        chk("dup_avail", out_ep_data_avail, 0);

        // DATA1 with bad CRC, then good retry
        pkt_buf[0] = 8'hA1; pkt_buf[1] = 8'hA2; pkt_buf[2] = 8'hA3;
        send_pkt(0, 1, 3, 0, ack);
        chk("crc_bad_ack", ack, 0);
        chk("crc_bad_avail", out_ep_data_avail, 0);
        send_pkt(0, 1, 3, 1, ack);
        chk("retry_ack", ack, 1);
        push_pkt(3);
        read_n(3, "retry_data");
        chk("retry_avail_after", out_ep_data_avail, 0);

        // two max packets fill the buffer; third overflows
        for (int i = 0; i < 64; i++) pkt_buf[i] = 8'(i);
        send_pkt(0, 0, 64, 1, ack);
        chk("fillA_ack", ack, 1);
        push_pkt(64);
        for (int i = 0; i < 64; i++) pkt_buf[i] = 8'(64 + i);
        send_pkt(0, 1, 64, 1, ack);
        chk("fillB_ack", ack, 1);
        push_pkt(64);
        chk("full_ready", ep_ready, 0);
        read_n(1, "full_get");
        for (int i = 0; i < 64; i++) pkt_buf[i] = 8'hF0 ^ 8'(i);
        send_pkt(0, 0, 64, 1, ack);
        chk("ovf_ack", ack, 0);
        chk("ovf_ready", ep_ready, 0);
        read_n(127, "drain_data");
        chk("drain_avail", out_ep_data_avail, 0);
        chk("drain_ready", ep_ready, 1);

        // SETUP packet, then DATA1 OUT
        for (int i = 0; i < 8; i++) pkt_buf[i] = 8'h30 + 8'(i);
        send_pkt(1, 0, 8, 1, ack);
        chk("setup_ack", ack, 1);
        chk("setup_flag", out_ep_setup, 1);
        push_pkt(8);
        read_n(7, "setup_data");
        chk("setup_flag_7", out_ep_setup, 1);
        read_n(1, "setup_data8");
        chk("setup_flag_8", out_ep_setup, 0);
        pkt_buf[0] = 8'hC1; pkt_buf[1] = 8'hC2;
        send_pkt(0, 1, 2, 1, ack);
        chk("after_setup_ack", ack, 1);
        chk("after_setup_flag", out_ep_setup, 0);
        push_pkt(2);
        read_n(2, "after_setup_data");

        // fill to full-minus-one across the wrap, then put+get together
        for (int i = 0; i < 64; i++) pkt_buf[i] = 8'h80 ^ 8'(i * 3);
        send_pkt(0, 0, 64, 1, ack);
        chk("wrapA_ack", ack, 1);
        push_pkt(64);
        for (int i = 0; i < 63; i++) pkt_buf[i] = 8'h55 ^ 8'(i * 7);
        send_pkt(0, 1, 63, 1, ack);
        chk("wrapB_ack", ack, 1);
        push_pkt(63);
        rx_pkt_start = 1'b1;
        tick();
        rx_pkt_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pkt_buf[i] = 8'hE0 + 8'(i);
            rx_data_put = 1'b1; rx_data = pkt_buf[i];
            out_ep_data_get = 1'b1;
            tick();
            chk("simul_rd", out_ep_data, exp_q.pop_front());
        end
        rx_data_put = 1'b0; out_ep_data_get = 1'b0;
        rx_pkt_end = 1'b1; rx_pkt_valid = 1'b1;
        tick();
        chk("simul_ack", out_ep_acked, 1);
        rx_pkt_end = 1'b0; rx_pkt_valid = 1'b0;
        push_pkt(5);
        read_n(127, "wrap_data");
        chk("wrap_avail", out_ep_data_avail, 0);
        chk("wrap_ready", ep_ready, 1);

        // stall mirror and grant removal
        out_ep_stall = 1'b1;
        tick();
        chk("stall_on", ep_stall, 1);
        out_ep_stall = 1'b0;
        tick();
        chk("stall_off", ep_stall, 0);
        pkt_buf[0] = 8'h5A;
        send_pkt(0, 1, 1, 1, ack);
        chk("late_ack", ack, 1);
        push_pkt(1);
        last_data = out_ep_data;
        out_ep_req = 1'b0;
        tick();
        chk("grant_drop", out_ep_grant, 0);
        out_ep_data_get = 1'b1;
        tick();
        out_ep_data_get = 1'b0;
        chk("nogrant_hold", out_ep_data, last_data);
        chk("nogrant_avail", out_ep_data_avail, 1);
        out_ep_req = 1'b1;
        tick();
        read_n(1, "late_data");

        // reset mid-packet discards everything; toggle back to DATA0
        rx_pkt_start = 1'b1;
        tick();
        rx_pkt_start = 1'b0;
        rx_data_put = 1'b1; rx_data = 8'h99;
        tick();
        rx_data_put = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("midrst_avail", out_ep_data_avail, 0);
        chk("midrst_data", out_ep_data, 8'h00);
        reset_n = 1'b1;
        tick(); tick();
        pkt_buf[0] = 8'h77;
        send_pkt(0, 0, 1, 1, ack);
        chk("postrst_ack", ack, 1);
        exp_q.delete();
        push_pkt(1);
        read_n(1, "postrst_data");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/usb_out_ep_buffer.md
# usb_out_ep_buffer

Packet-level receive buffer for one USB full-speed bulk/control OUT endpoint. It sits between the USB protocol engine's receive path and the endpoint consumer, for example the SPI bridge. It stores incoming DATA packets speculatively and commits or rewinds each one on CRC result and data-toggle check. It then presents committed bytes through the endpoint req/grant/data_avail/data_get handshake, with read data valid one cycle after the get.

## Interface
- DEPTH, 128: buffer bytes; power of two, at least 2*MAX_PKT.
- MAX_PKT, 64: maximum packet payload in bytes; sets the NAK threshold.
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- rx_pkt_start  in  1  pulse: DATA packet for this endpoint begins.
- rx_pkt_setup  in  1  qualifies rx_pkt_start; packet follows a SETUP token.
- rx_pid_data1  in  1  sampled with rx_pkt_start; 1 = DATA1 PID.
- rx_data_put  in  1  pulse: rx_data is the next payload byte.
- rx_data  in  8  payload byte.
- rx_pkt_end  in  1  pulse: packet finished.
- rx_pkt_valid  in  1  sampled with rx_pkt_end; 1 = CRC good.
- ep_ready  out  1  free space >= MAX_PKT; the protocol engine NAKs when this is 0.
- ep_stall  out  1  registered copy of out_ep_stall, returned to the protocol engine.
- out_ep_req  in  1  consumer requests access.
- out_ep_grant  out  1  access granted.
- out_ep_data_avail  out  1  at least one committed unread byte.
- out_ep_setup  out  1  buffered data belongs to a SETUP packet.
- out_ep_data_get  in  1  consume one byte.
- out_ep_data  out  8  byte read by the previous accepted get.
- out_ep_stall  in  1  consumer stall request.
- out_ep_acked  out  1  one-cycle pulse: packet accepted (ACK returned).

## Operation
- Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. There are three:
  - rd_ptr: next byte the consumer reads.
  - commit_ptr: end of the last committed packet.
  - wr_ptr: speculative write position.
- Definitions:
  - empty = (rd_ptr == commit_ptr).
  - used = wr_ptr - rd_ptr, modulo 2*DEPTH.
  - full = (used == DEPTH).
- Receive FSM states: RX_IDLE, RX_DATA, RX_DROP.
  - RX_IDLE to RX_DATA on rx_pkt_start. At that point wr_ptr <= commit_ptr, and the PID and setup flag are latched.
  - In RX_DATA, rx_data_put writes mem[wr_ptr] and increments wr_ptr.
    - A put while full goes to RX_DROP with no write.
    - A put when the byte count already equals MAX_PKT also goes to RX_DROP with no write.
  - In RX_DROP, puts are ignored.
  - rx_pkt_end in RX_DATA returns to RX_IDLE with one of these outcomes:
    - rx_pkt_valid=1 and PID matches the expected toggle: commit_ptr <= wr_ptr, expected toggle flips, out_ep_acked pulses.
    - rx_pkt_valid=1 and PID mismatches (a retransmission): wr_ptr <= commit_ptr, toggle unchanged, out_ep_acked pulses.
    - rx_pkt_valid=0: wr_ptr <= commit_ptr, no pulse.
  - rx_pkt_end in RX_DROP rewinds wr_ptr <= commit_ptr, with no pulse, and returns to RX_IDLE.
  - rx_pkt_start in RX_DATA or RX_DROP rewinds, then restarts in RX_DATA.
- SETUP packets bypass the toggle check; the packet must be DATA0. On commit:
  - the expected toggle is set to DATA1;
  - out_ep_setup is set to 1.
- out_ep_setup clears on the cycle the buffer becomes empty through a get.
- Expected toggle resets to DATA0.
- Arbitration:
  - out_ep_grant <= out_ep_req, registered.
  - out_ep_data_avail = !empty, combinational from pointers.
- Read:
  - An accepted get is out_ep_data_get && out_ep_grant && out_ep_data_avail.
  - An accepted get registers out_ep_data <= mem[rd_ptr] and increments rd_ptr.
  - A get that is not accepted has no effect; out_ep_data holds its value.
- ep_ready is registered: (DEPTH - used) >= MAX_PKT.
- Simultaneous get and write or commit are both honoured in the same cycle. A commit never overwrites unread bytes, because writes stop at full.

## Timing
- Reset values:
  - out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_acked, ep_stall: 0.
  - out_ep_data: 8'h00.
  - ep_ready: 1.
  - All pointers: 0.
  - FSM: RX_IDLE.
  - Expected toggle: DATA0.
- Reset asserted mid-packet or mid-read discards everything.
- Grant latency: 1 cycle after req; grant drops 1 cycle after req drops.
- Read latency: out_ep_data is valid the cycle after the accepted get. Back-to-back gets deliver one byte per cycle.
- Commit to data visibility:
  - commit_ptr updates on the clock edge that samples rx_pkt_end.
  - out_ep_data_avail rises in the following cycle.
  - out_ep_acked pulses in that same following cycle, registered.
- ep_ready and ep_stall each lag their inputs by 1 cycle.

## Test plan
- Reset, then a DATA0 packet of 4 bytes (11, 22, 33, 44) with valid CRC:
  - acked pulses once, avail=1, setup=0;
  - with req held, 4 consecutive gets return 11, 22, 33, 44, each one cycle after its get;
  - avail=0 after the 4th get.
- A second DATA0 packet after the toggle has advanced: acked pulses, no bytes are added, and avail stays 0.
- A DATA1 packet of 3 bytes with rx_pkt_valid=0: no acked, no data. A retry of the same 3 bytes with valid CRC: acked pulses, exactly 3 bytes are readable.
- DEPTH=128, MAX_PKT=64:
  - two 64-byte packets are committed, so ep_ready=0;
  - one get, then a third packet is attempted: it overflows and is dropped, with no acked;
  - rd_ptr and commit_ptr are consistent after 127 more gets, and ep_ready=1 once 64 or more bytes are free.
- A SETUP packet of 8 bytes: setup=1 until the 8th get, then 0. A following DATA1 OUT packet is accepted.
- rx_data_put issued on the same cycle as an accepted get at full-minus-one: both the write and the read happen, and byte order is preserved across the wrap at address 127 to 0.
